// File: rtl/button_conditioner_if.sv
`default_nettype none
// ============================================================================
//  Module      : button_conditioner_if
//  Description : Signal bundle between the tug-of-war button conditioner and
//                its environment. The master side supplies the sample tick,
//                the round-live gate and the raw buttons; the slave side
//                (the conditioner) returns press pulses and debounced levels.
//  Revision    : 1.0 - initial release
// ============================================================================
interface button_conditioner_if;
  // Inputs to the conditioner
  logic slowen;   // one-clk sample tick from the clock-enable divider
  logic arm;      // high while a round is live
  logic btn_l;    // raw left button, asynchronous
  logic btn_r;    // raw right button, asynchronous
  // Outputs from the conditioner
  logic push_l;   // one-clk pulse: left press accepted
  logic push_r;   // one-clk pulse: right press accepted
  logic tie;      // one-clk pulse: both presses accepted together
  logic held_l;   // debounced left level
  logic held_r;   // debounced right level

  modport master (
    output slowen, arm, btn_l, btn_r,
    input  push_l, push_r, tie, held_l, held_r
  );

  modport slave (
    input  slowen, arm, btn_l, btn_r,
    output push_l, push_r, tie, held_l, held_r
  );
endinterface
`default_nettype wire

// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : button_conditioner
//  Description : Cleans the two raw player buttons of the tug-of-war game.
//                Each channel is double-flop synchronised, debounced on the
//                1-in-256 slowen tick, and edge-detected. Accepted presses
//                become single-clk pulses, gated by arm, with a same-cycle
//                tie pulse replacing both individual pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module button_conditioner #(
  parameter int STABLE_TICKS = 4,   // ticks a new level must hold (2..15)
  parameter int CW           = 4    // debounce counter width, 2^CW > STABLE_TICKS
) (
  input  logic                  clk,
  input  logic                  rst,
  button_conditioner_if.slave   bus
);

  // Count value at which the next disagreeing tick commits the new level.
  localparam logic [CW-1:0] c_last = CW'(STABLE_TICKS - 1);

  // Channel index 0 = left player, 1 = right player.
  logic [1:0] w_btn;
  logic [1:0] w_held;
  logic [1:0] w_rise;

  assign w_btn = {bus.btn_r, bus.btn_l};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
      logic          r_s1;      // first synchroniser stage (may be metastable)
      logic          r_s2;      // second stage, the value the debouncer sees
      logic          r_held;    // debounced level
      logic          r_held_d;  // debounced level one clk later
      logic [CW-1:0] r_cnt;     // consecutive disagreeing ticks seen so far

      // Bring the asynchronous button into the clk domain.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_s1 <= 1'b0;
          r_s2 <= 1'b0;
        end else begin
          r_s1 <= w_btn[gi];
          r_s2 <= r_s1;
        end
      end

      // Accept a new level only after it disagrees with held on
      // STABLE_TICKS consecutive ticks; any agreeing tick restarts the run,
      // so short glitches never reach held.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_cnt  <= '0;
          r_held <= 1'b0;
        end else if (bus.slowen) begin
          if (r_s2 == r_held) begin
            r_cnt <= '0;
          end else if (r_cnt == c_last) begin
            r_held <= r_s2;
            r_cnt  <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
      end

      // Delay held by one clk so a rising edge is visible for one cycle.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_held_d <= 1'b0;
        end else begin
          r_held_d <= r_held;
        end
      end

      // Only the 0->1 transition of the debounced level is a press.
      assign w_held[gi] = r_held;
      assign w_rise[gi] = r_held & ~r_held_d;
    end
  endgenerate

  logic r_push_l;
  logic r_push_r;
  logic r_tie;

  // Register the press pulses; a disarmed round swallows rises outright
  // and simultaneous rises collapse into a single tie pulse.
  always_ff @(posedge clk) begin
    if (rst || !bus.arm) begin
      r_push_l <= 1'b0;
      r_push_r <= 1'b0;
      r_tie    <= 1'b0;
    end else begin
      r_tie    <= w_rise[0] &  w_rise[1];
      r_push_l <= w_rise[0] & ~w_rise[1];
      r_push_r <= w_rise[1] & ~w_rise[0];
    end
  end

  assign bus.push_l = r_push_l;
  assign bus.push_r = r_push_r;
  assign bus.tie    = r_tie;
  assign bus.held_l = w_held[0];
  assign bus.held_r = w_held[1];

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_button_conditioner
//  Description : Directed self-checking bench for button_conditioner with
//                STABLE_TICKS = 4 and slowen pulsed every 4th clk. Stimulus
//                is aligned to a tick edge (P0) so every expected edge below
//                is a fixed clk index: s2 sees a change at P2, the ticks at
//                P4/P8/P12/P16 commit held at P16, and the pulse is high
//                during the cycle after P17.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_button_conditioner;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   phase;

  button_conditioner_if bus ();

  button_conditioner #(
    .STABLE_TICKS (4),
    .CW           (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // slowen: changed on the falling edge, high for one full clk every 4 clks
  initial begin
    phase      = 0;
    bus.slowen = 1'b0;
    forever begin
      @(negedge clk);
      phase      = (phase + 1) % 4;
      bus.slowen = (phase == 0);
    end
  end

  // Absolute run-time bound
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Step to the first posedge that sampled slowen=1, then #1 past it
  task automatic align_tick();
    int guard;
    guard = 0;
    do begin
      @(posedge clk);
      #1;
      guard++;
    end while (phase != 0 && guard < 8);
    checks++;
    if (phase != 0) begin
      failures++;
      $display("FAIL align_tick: phase=%0d required 0", phase);
    end
  endtask

  // Release both buttons; held must fall and no pulse may appear
  task automatic release_all();
    int np;
    np = 0;
    bus.btn_l = 1'b0;
    bus.btn_r = 1'b0;
    for (int k = 0; k < 48; k++) begin
      @(negedge clk);
      if (bus.push_l || bus.push_r || bus.tie) np++;
      @(posedge clk);
      #1;
    end
    checks++;
    if ({bus.held_l, bus.held_r} !== 2'b00) begin
      failures++;
      $display("FAIL release_held: held_l/r=%b%b required 00", bus.held_l, bus.held_r);
    end
    checks++;
    if (np !== 0) begin
      failures++;
      $display("FAIL release_nopulse: pulses=%0d required 0", np);
    end
  endtask

  task automatic test_reset();
    int n_tie, n_push;
    bus.arm   = 1'b1;
    bus.btn_l = 1'b1;
    bus.btn_r = 1'b1;
    rst       = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      checks++;
      if ({bus.held_l, bus.held_r, bus.push_l, bus.push_r, bus.tie} !== 5'b00000) begin
        failures++;
        $display("FAIL reset_outputs: held_l,held_r,push_l,push_r,tie=%b%b%b%b%b required 00000",
                 bus.held_l, bus.held_r, bus.push_l, bus.push_r, bus.tie);
      end
    end
    align_tick();
    rst    = 1'b0;
    n_tie  = 0;
    n_push = 0;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      if (bus.tie) n_tie++;
      if (bus.push_l || bus.push_r) n_push++;
      if (k == 15) begin
        checks++;
        if (bus.held_l !== 1'b0) begin
          failures++;
          $display("FAIL reset_held_early: held_l=%b required 0 at P15", bus.held_l);
        end
      end
      if (k == 16) begin
        checks++;
        if (bus.held_l !== 1'b1) begin
          failures++;
          $display("FAIL reset_held_4ticks: held_l=%b required 1 at P16", bus.held_l);
        end
      end
      if (k == 17) begin
        checks++;
        if (bus.tie !== 1'b1) begin
          failures++;
          $display("FAIL reset_tie: tie=%b required 1 at P17", bus.tie);
        end
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (n_tie !== 1 || n_push !== 0) begin
      failures++;
      $display("FAIL reset_pulse_count: tie=%0d push=%0d required 1 and 0", n_tie, n_push);
    end
  endtask

  task automatic test_clean_press();
    int n_l, n_r, n_t;
    n_l = 0; n_r = 0; n_t = 0;
    align_tick();
    bus.btn_l = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.push_l) n_l++;
      if (bus.push_r) n_r++;
      if (bus.tie)    n_t++;
      if (k == 15) begin
        checks++;
        if (bus.held_l !== 1'b0) begin
          failures++;
          $display("FAIL clean_held_early: held_l=%b required 0 at P15", bus.held_l);
        end
      end
      if (k == 16) begin
        checks++;
        if (bus.held_l !== 1'b1 || bus.push_l !== 1'b0) begin
          failures++;
          $display("FAIL clean_held_rise: held_l=%b push_l=%b required 1 0 at P16", bus.held_l, bus.push_l);
        end
      end
      if (k == 17) begin
        checks++;
        if (bus.push_l !== 1'b1) begin
          failures++;
          $display("FAIL clean_push_latency: push_l=%b required 1 at P17", bus.push_l);
        end
      end
      if (k == 18) begin
        checks++;
        if (bus.push_l !== 1'b0) begin
          failures++;
          $display("FAIL clean_push_width: push_l=%b required 0 at P18", bus.push_l);
        end
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (n_l !== 1 || n_r !== 0 || n_t !== 0) begin
      failures++;
      $display("FAIL clean_counts: push_l=%0d push_r=%0d tie=%0d required 1 0 0", n_l, n_r, n_t);
    end
  endtask

  task automatic test_bounce();
    int n_r, n_other;
    n_r = 0; n_other = 0;
    align_tick();
    bus.btn_r = 1'b1;
    // btn_r for cycle k: toggles every 3 clk for k<30, then stays 1.
    // Ticks at P4..P32 see at most two 1s in a row; P36..P48 are clean.
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (bus.push_r) n_r++;
      if (bus.push_l || bus.tie) n_other++;
      if (k == 47) begin
        checks++;
        if (bus.held_r !== 1'b0 || n_r !== 0) begin
          failures++;
          $display("FAIL bounce_quiet: held_r=%b pushes=%0d required 0 0 at P47", bus.held_r, n_r);
        end
      end
      if (k == 48) begin
        checks++;
        if (bus.held_r !== 1'b1) begin
          failures++;
          $display("FAIL bounce_held: held_r=%b required 1 at P48", bus.held_r);
        end
      end
      if (k == 49) begin
        checks++;
        if (bus.push_r !== 1'b1) begin
          failures++;
          $display("FAIL bounce_push: push_r=%b required 1 at P49", bus.push_r);
        end
      end
      @(posedge clk);
      #1;
      bus.btn_r = (k + 1 >= 30) ? 1'b1 : ((((k + 1) / 3) % 2) == 0);
    end
    checks++;
    if (n_r !== 1 || n_other !== 0) begin
      failures++;
      $display("FAIL bounce_counts: push_r=%0d others=%0d required 1 0", n_r, n_other);
    end
  endtask

  task automatic test_simultaneous();
    int n_t, n_p;
    n_t = 0; n_p = 0;
    align_tick();
    bus.btn_l = 1'b1;
    bus.btn_r = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (bus.tie) n_t++;
      if (bus.push_l || bus.push_r) n_p++;
      if (k == 17) begin
        checks++;
        if (bus.tie !== 1'b1 || bus.push_l !== 1'b0 || bus.push_r !== 1'b0) begin
          failures++;
          $display("FAIL simul_tie: tie,push_l,push_r=%b%b%b required 100 at P17",
                   bus.tie, bus.push_l, bus.push_r);
        end
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (n_t !== 1 || n_p !== 0) begin
      failures++;
      $display("FAIL simul_counts: tie=%0d push=%0d required 1 0", n_t, n_p);
    end
    checks++;
    if ({bus.held_l, bus.held_r} !== 2'b11) begin
      failures++;
      $display("FAIL simul_held: held_l/r=%b%b required 11", bus.held_l, bus.held_r);
    end
  endtask

  task automatic test_arm_gate();
    int n_l;
    n_l = 0;
    bus.arm = 1'b0;
    align_tick();
    bus.btn_l = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.push_l || bus.tie || bus.push_r) n_l++;
      @(posedge clk);
      #1;
      if (k == 20) bus.arm = 1'b1;
    end
    checks++;
    if (n_l !== 0 || bus.held_l !== 1'b1) begin
      failures++;
      $display("FAIL arm_swallow: pulses=%0d held_l=%b required 0 1", n_l, bus.held_l);
    end
    release_all();
    n_l = 0;
    align_tick();
    bus.btn_l = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (bus.push_l) n_l++;
      if (k == 17) begin
        checks++;
        if (bus.push_l !== 1'b1) begin
          failures++;
          $display("FAIL arm_repress: push_l=%b required 1 at P17", bus.push_l);
        end
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (n_l !== 1) begin
      failures++;
      $display("FAIL arm_repress_count: push_l=%0d required 1", n_l);
    end
  endtask

  task automatic test_mid_reset();
    int n_r;
    n_r = 0;
    align_tick();
    bus.btn_r = 1'b1;
    // Ticks P4/P8 count 2; reset at P9 clears everything; s2 is back at 1
    // before P12, so ticks P12..P24 are the four that commit held.
    for (int k = 0; k < 36; k++) begin
      @(negedge clk);
      if (bus.push_r) n_r++;
      if (k == 9) begin
        checks++;
        if ({bus.held_r, bus.push_r, bus.tie} !== 3'b000) begin
          failures++;
          $display("FAIL midrst_cleared: held_r,push_r,tie=%b%b%b required 000",
                   bus.held_r, bus.push_r, bus.tie);
        end
      end
      if (k == 23) begin
        checks++;
        if (bus.held_r !== 1'b0) begin
          failures++;
          $display("FAIL midrst_held_early: held_r=%b required 0 at P23", bus.held_r);
        end
      end
      if (k == 24) begin
        checks++;
        if (bus.held_r !== 1'b1) begin
          failures++;
          $display("FAIL midrst_held: held_r=%b required 1 at P24", bus.held_r);
        end
      end
      if (k == 25) begin
        checks++;
        if (bus.push_r !== 1'b1) begin
          failures++;
          $display("FAIL midrst_push: push_r=%b required 1 at P25", bus.push_r);
        end
      end
      @(posedge clk);
      #1;
      if (k == 7) rst = 1'b1;
      if (k == 8) rst = 1'b0;
    end
    checks++;
    if (n_r !== 1) begin
      failures++;
      $display("FAIL midrst_count: push_r=%0d required 1", n_r);
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    bus.arm   = 1'b1;
    bus.btn_l = 1'b0;
    bus.btn_r = 1'b0;
    test_reset();
    release_all();
    test_clean_press();
    release_all();
    test_bounce();
    release_all();
    test_simultaneous();
    release_all();
    test_arm_gate();
    release_all();
    test_mid_reset();
    release_all();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
